// File: rtl/video_scanout.sv
// Raster timing generator and VRAM reader for a 640x480-class display.
// Drives the registered VRAM read port and aligns returned pixels with de/hsync/vsync.
module video_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [9:0]  vx0,
  output logic [9:0]  vy0,
  output logic        vr0,
  input  logic [23:0] vo,
  output logic [23:0] pix_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       run;
  logic       tick;
  logic       active;
  logic       hs0;
  logic       vs0;
  logic       first;

  logic       s1_active;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_first;

  // Nothing advances until run is set, so the first read after reset is at (0,0).
  assign tick   = run & pix_ce;
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs0    = (hcnt >= HS_START) && (hcnt <= HS_END);
  assign vs0    = (vcnt >= VS_START) && (vcnt <= VS_END);
  assign first  = (hcnt == 10'd0) && (vcnt == 10'd0);

  assign vr0 = tick & active;
  assign vx0 = active ? hcnt : 10'd0;
  assign vy0 = active ? vcnt : 10'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else begin
      run <= 1'b1;
      if (tick) begin
        if (hcnt == H_LAST) begin
          hcnt <= 10'd0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Stage 1 tracks the VRAM read latency; the output stage pairs vo with its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_active   <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_first    <= 1'b0;
      pix_rgb     <= 24'h0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else if (tick) begin
      s1_active   <= active;
      s1_hs       <= hs0;
      s1_vs       <= vs0;
      s1_first    <= first;
      pix_rgb     <= s1_active ? vo : 24'h0;
      de          <= s1_active;
      hsync       <= s1_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= s1_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= s1_first;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout using a reduced raster (15x8 totals).
// Table-driven pixel/sync vectors plus frame sweeps, pix_ce gaps and mid-frame reset.
module tb_video_scanout;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSW = 3;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VSW = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_ce = 1'b1;
  logic [9:0]  vx0;
  logic [9:0]  vy0;
  logic        vr0;
  logic [23:0] vo = 24'h0;
  logic [23:0] pix_rgb;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  int ce_div = 1;
  int phase = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int          n;
    logic        de;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  vec_t tab[15];

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .vx0(vx0),
    .vy0(vy0),
    .vr0(vr0),
    .vo(vo),
    .pix_rgb(pix_rgb),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // VRAM stand-in: registered read returning the requested coordinates.
  always @(posedge clk) begin
    if (vr0) vo <= {2'b00, vy0, 2'b00, vx0};
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ce_div <= 1) begin
        pix_ce = 1'b1;
      end else begin
        pix_ce = (phase == 0);
        phase = (phase + 1) % ce_div;
      end
    end
  end

  function automatic logic [23:0] pix(input int line, input int col);
    return {2'b00, line[9:0], 2'b00, col[9:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FT * 10; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, 32'(pix_rgb), 32'h0);
    check({tag, "_de"}, 32'(de), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_vr0"}, 32'(vr0), 32'd0);
    check({tag, "_vx0"}, 32'(vx0), 32'd0);
    check({tag, "_vy0"}, 32'(vy0), 32'd0);
  endtask

  // Release reset and follow the first read through to frame_start.
  task automatic release_seq(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check({tag, "_vr0_first_clk"}, 32'(vr0), 32'd0);
    @(negedge clk);
    check({tag, "_vr0_first_read"}, 32'(vr0), 32'd1);
    check({tag, "_vx0_first_read"}, 32'(vx0), 32'd0);
    check({tag, "_vy0_first_read"}, 32'(vy0), 32'd0);
    check({tag, "_fs_early0"}, 32'(frame_start), 32'd0);
    @(negedge clk);
    check({tag, "_fs_early1"}, 32'(frame_start), 32'd0);
    @(negedge clk);
    check({tag, "_fs_after_2_ticks"}, 32'(frame_start), 32'd1);
    check({tag, "_de_at_fs"}, 32'(de), 32'd1);
  endtask

  task automatic sweep(input int d, input string tag);
    bit ok;
    bit de_prev = 1'b0;
    bit hs_prev = 1'b1;
    bit vs_prev = 1'b1;
    int fs_cnt = 0, last_fs = -1, fs_bad = 0, fs_de_err = 0;
    int line = 0, k = 0, runs = 0, bad_run = 0, pix_err = 0, blank_err = 0, last_de_rise = -1;
    int hs_lo = 0, hs_falls = 0, hs_bad_len = 0, last_hs = -1, hs_bad_per = 0, hs_off_err = 0;
    int vs_lo = 0, vs_falls = 0, vs_bad_len = 0, last_vs = -1, vs_bad_per = 0;
    int rd_cnt = 0, rd_gap_err = 0, addr_err = 0;
    wait_fs(ok);
    if (!ok) return;
    for (int n = 0; n <= FT * 3 * d; n++) begin
      if (n > 0) @(negedge clk);
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0 && n - last_fs != FT * d) fs_bad++;
        if (!de) fs_de_err++;
        last_fs = n;
      end
      if (de && !de_prev) begin
        if (frame_start) line = 0;
        else line++;
        k = 0;
        last_de_rise = n;
      end
      if (!de && de_prev) begin
        runs++;
        if (k != HA * d) bad_run++;
      end
      if (de) begin
        if (pix_rgb !== pix(line, k / d)) pix_err++;
        k++;
      end else if (pix_rgb !== 24'h0) begin
        blank_err++;
      end
      if (!hsync && hs_prev) begin
        hs_falls++;
        if (last_hs >= 0 && n - last_hs != HT * d) hs_bad_per++;
        if (last_de_rise >= 0 && n - last_de_rise < HT * d && n - last_de_rise != (HA + HF) * d)
          hs_off_err++;
        last_hs = n;
        hs_lo = 0;
      end
      if (!hsync) hs_lo++;
      if (hsync && !hs_prev && hs_lo != HSW * d) hs_bad_len++;
      if (!vsync && vs_prev) begin
        vs_falls++;
        if (last_vs >= 0 && n - last_vs != FT * d) vs_bad_per++;
        last_vs = n;
        vs_lo = 0;
      end
      if (!vsync) vs_lo++;
      if (vsync && !vs_prev && vs_lo != VSW * HT * d) vs_bad_len++;
      if (n < FT * 3 * d && vr0) rd_cnt++;
      if (vr0 && !pix_ce) rd_gap_err++;
      if (pix_ce && !vr0 && (vx0 != 10'd0 || vy0 != 10'd0)) addr_err++;
      if (vr0 && (vx0 >= 10'(HA) || vy0 >= 10'(VA))) addr_err++;
      de_prev = de;
      hs_prev = hsync;
      vs_prev = vsync;
    end
    check({tag, "_fs_count"}, 32'(fs_cnt), 32'd4);
    check({tag, "_fs_period"}, 32'(fs_bad), 32'd0);
    check({tag, "_fs_with_de"}, 32'(fs_de_err), 32'd0);
    check({tag, "_de_runs"}, 32'(runs), 32'(3 * VA));
    check({tag, "_de_run_len"}, 32'(bad_run), 32'd0);
    check({tag, "_pixel_values"}, 32'(pix_err), 32'd0);
    check({tag, "_blank_rgb_zero"}, 32'(blank_err), 32'd0);
    check({tag, "_hs_falls"}, 32'(hs_falls), 32'(3 * VT));
    check({tag, "_hs_len"}, 32'(hs_bad_len), 32'd0);
    check({tag, "_hs_period"}, 32'(hs_bad_per), 32'd0);
    check({tag, "_hs_offset"}, 32'(hs_off_err), 32'd0);
    check({tag, "_vs_falls"}, 32'(vs_falls), 32'd3);
    check({tag, "_vs_len"}, 32'(vs_bad_len), 32'd0);
    check({tag, "_vs_period"}, 32'(vs_bad_per), 32'd0);
    check({tag, "_read_count"}, 32'(rd_cnt), 32'(3 * HA * VA));
    check({tag, "_read_in_gap"}, 32'(rd_gap_err), 32'd0);
    check({tag, "_blank_addr"}, 32'(addr_err), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;

    // n counts clks from the frame_start clk; hand-derived for the 15x8 raster.
    tab[0]  = '{0,   1'b1, 24'h000000, 1'b1, 1'b1, 1'b1};
    tab[1]  = '{1,   1'b1, 24'h000001, 1'b1, 1'b1, 1'b0};
    tab[2]  = '{7,   1'b1, 24'h000007, 1'b1, 1'b1, 1'b0};
    tab[3]  = '{8,   1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    tab[4]  = '{10,  1'b0, 24'h000000, 1'b0, 1'b1, 1'b0};
    tab[5]  = '{12,  1'b0, 24'h000000, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{13,  1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    tab[7]  = '{15,  1'b1, 24'h001000, 1'b1, 1'b1, 1'b0};
    tab[8]  = '{50,  1'b1, 24'h003005, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{60,  1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    tab[10] = '{75,  1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tab[11] = '{104, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tab[12] = '{105, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    tab[13] = '{119, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
    tab[14] = '{120, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b1};

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_seq("por");

    n = 0;
    for (int i = 0; i < 15; i++) begin
      while (n < tab[i].n) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d_de", i), 32'(de), 32'(tab[i].de));
      check($sformatf("vec%0d_rgb", i), 32'(pix_rgb), 32'(tab[i].rgb));
      check($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(tab[i].hs));
      check($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(tab[i].vs));
      check($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(tab[i].fs));
    end

    sweep(1, "ce1");
    ce_div = 4;
    sweep(4, "ce4");
    ce_div = 1;

    // Mid-frame reset at line 2, column 5 while a pixel is being shown.
    wait_fs(ok);
    repeat (2 * HT + 5) @(negedge clk);
    check("pre_reset_de", 32'(de), 32'd1);
    check("pre_reset_rgb", 32'(pix_rgb), 32'h002005);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    release_seq("midrst");
    @(negedge clk);
    check("midrst_second_pixel", 32'(pix_rgb), 32'h000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
